// File: rtl/twin_ser_pkg.sv
// twin_ser_pkg: shared types and defaults for the twin pair serializer.
// Build option: TWIN_SER_CHECKSUM_EN adds an XOR checksum word per frame.
package twin_ser_pkg;

  localparam int TWIN_SER_DW    = 8;
  localparam int TWIN_SER_DEPTH = 4;

`ifdef TWIN_SER_CHECKSUM_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_A  = 2'd1,
    SEND_B  = 2'd2,
    SEND_CK = 2'd3
  } state_t;

endpackage

// File: rtl/twin_pair_fifo.sv
// twin_pair_fifo: synchronous FIFO holding one register pair per entry.
// The read word is the current head (show-ahead); pop advances it.
module twin_pair_fifo
  import twin_ser_pkg::*;
#(
  parameter int WIDTH = 2 * TWIN_SER_DW,
  parameter int DEPTH = TWIN_SER_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care after reset since level gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy counter; simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/twin_pair_serializer.sv
// twin_pair_serializer: buffers (A, B) register pairs and streams them as
// A, B[, A^B] frames with out_last on the final word.
// Build option: TWIN_SER_CHECKSUM_EN appends the A^B checksum word.
//
//   state   | meaning
//   IDLE    | no frame in flight, waiting for a queued pair
//   SEND_A  | presenting first word (hold_a)
//   SEND_B  | presenting second word (hold_b)
//   SEND_CK | presenting checksum hold_a ^ hold_b (checksum build only)
module twin_pair_serializer
  import twin_ser_pkg::*;
#(
  parameter int DW    = TWIN_SER_DW,
  parameter int DEPTH = TWIN_SER_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_a,
  input  logic [DW-1:0]          in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic LAST_ON_B = (FRAME_LEN == 2);

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   hold_a;
  logic [DW-1:0]   hold_b;
  logic [2*DW-1:0] head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            frame_done;
  logic [DW-1:0]   data_nx;
  logic            valid_nx;
  logic            last_nx;

  // No pass-through: readiness depends on the stored level only.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  twin_pair_fifo #(
    .WIDTH (2 * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state and next registered output values.
  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    frame_done = 1'b0;
    data_nx    = out_data;
    valid_nx   = out_valid;
    last_nx    = out_last;

    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = SEND_A;
          data_nx  = head[2*DW-1:DW];
          valid_nx = 1'b1;
        end
      end
      SEND_A: begin
        if (out_ready) begin
          state_nx = SEND_B;
          data_nx  = hold_b;
          last_nx  = LAST_ON_B;
        end
      end
      SEND_B: begin
        if (out_ready) begin
`ifdef TWIN_SER_CHECKSUM_EN
          state_nx = SEND_CK;
          data_nx  = hold_a ^ hold_b;
          last_nx  = 1'b1;
`else
          frame_done = 1'b1;
`endif
        end
      end
`ifdef TWIN_SER_CHECKSUM_EN
      SEND_CK: begin
        if (out_ready) begin
          frame_done = 1'b1;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
      end
    endcase

    // End of frame: chain straight into the next pair so frames have no bubble.
    if (frame_done) begin
      if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = SEND_A;
        data_nx  = head[2*DW-1:DW];
        valid_nx = 1'b1;
        last_nx  = 1'b0;
      end else begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
      end
    end
  end

  // FSM state and registered output stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      out_last  <= last_nx;
    end
  end

  // Holding registers capture the head pair whenever it is popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (pop) begin
      hold_a <= head[2*DW-1:DW];
      hold_b <= head[DW-1:0];
    end
  end

endmodule

// File: tb/tb_twin_pair_serializer.sv
// tb_twin_pair_serializer: directed table vectors plus hand sequences for
// full-FIFO refusal and reset in the middle of a frame (default build).
module tb_twin_pair_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [2:0] level;

  int n_checks = 0;
  int n_pass   = 0;

  twin_pair_serializer #(.DW(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] a;
    logic [7:0] b;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic [2:0] elev;
    logic       eir;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mkv(bit iv, int a, int b, bit ordy,
                               bit ev, int ed, bit el, int lev, bit eir);
    vec_t v;
    v.iv   = iv;
    v.a    = 8'(a);
    v.b    = 8'(b);
    v.ordy = ordy;
    v.ev   = ev;
    v.ed   = 8'(ed);
    v.el   = el;
    v.elev = 3'(lev);
    v.eir  = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic ordy);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
  endtask

  logic [7:0] got_q[$];
  logic [7:0] exp_words[8];

  initial begin
    rst = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    #3;
    chk("por_valid", 32'(out_valid), 0);
    chk("por_level", 32'(level), 0);
    chk("por_in_ready", 32'(in_ready), 1);
    chk("por_data", 32'(out_data), 0);
    step();
    step();
    rst = 1'b1;

    // single pair, back-to-back frames, backpressure in SEND_B and SEND_A
    tbl[0]  = mkv(1,  1, 10, 1,  0,  0, 0, 1, 1);
    tbl[1]  = mkv(0,  0,  0, 1,  1,  1, 0, 0, 1);
    tbl[2]  = mkv(0,  0,  0, 1,  1, 10, 1, 0, 1);
    tbl[3]  = mkv(0,  0,  0, 1,  0,  0, 0, 0, 1);
    tbl[4]  = mkv(1, 17, 33, 1,  0,  0, 0, 1, 1);
    tbl[5]  = mkv(1, 21, 16, 1,  1, 17, 0, 1, 1);
    tbl[6]  = mkv(0,  0,  0, 1,  1, 33, 1, 1, 1);
    tbl[7]  = mkv(0,  0,  0, 1,  1, 21, 0, 0, 1);
    tbl[8]  = mkv(0,  0,  0, 1,  1, 16, 1, 0, 1);
    tbl[9]  = mkv(0,  0,  0, 1,  0,  0, 0, 0, 1);
    tbl[10] = mkv(1,  3,  4, 0,  0,  0, 0, 1, 1);
    tbl[11] = mkv(0,  0,  0, 1,  1,  3, 0, 0, 1);
    tbl[12] = mkv(0,  0,  0, 1,  1,  4, 1, 0, 1);
    tbl[13] = mkv(0,  0,  0, 0,  1,  4, 1, 0, 1);
    tbl[14] = mkv(0,  0,  0, 0,  1,  4, 1, 0, 1);
    tbl[15] = mkv(0,  0,  0, 1,  0,  0, 0, 0, 1);
    tbl[16] = mkv(1,  5,  6, 0,  0,  0, 0, 1, 1);
    tbl[17] = mkv(0,  0,  0, 0,  1,  5, 0, 0, 1);
    tbl[18] = mkv(0,  0,  0, 0,  1,  5, 0, 0, 1);
    tbl[19] = mkv(0,  0,  0, 1,  1,  6, 1, 0, 1);
    tbl[20] = mkv(0,  0,  0, 1,  0,  0, 0, 0, 1);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].ordy);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].elev));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].el));
      end
    end

    // Full FIFO: pair 0 sits in the hold regs, pairs 1..4 fill the FIFO.
    begin
      int exp_lev[5] = '{1, 1, 2, 3, 4};
      int exp_ir[5]  = '{1, 1, 1, 1, 0};
      for (int p = 0; p < 5; p++) begin
        drive(1'b1, 8'(8'h10 + p), 8'(8'h20 + p), 1'b0);
        step();
        chk($sformatf("full_push%0d_level", p), 32'(level), 32'(exp_lev[p]));
        chk($sformatf("full_push%0d_in_ready", p), 32'(in_ready), 32'(exp_ir[p]));
      end
    end
    chk("full_hold_data", 32'(out_data), 32'h10);
    drive(1'b1, 8'h15, 8'h25, 1'b0);
    step();
    chk("full_refuse_level", 32'(level), 4);
    chk("full_refuse_in_ready", 32'(in_ready), 0);
    drive(1'b1, 8'h15, 8'h25, 1'b1);
    step();
    chk("full_b0_data", 32'(out_data), 32'h20);
    chk("full_b0_level", 32'(level), 4);
    step();
    chk("full_pop_data", 32'(out_data), 32'h11);
    chk("full_no_passthru_level", 32'(level), 3);
    chk("full_pop_in_ready", 32'(in_ready), 1);
    step();
    chk("full_accept_level", 32'(level), 4);
    chk("full_accept_data", 32'(out_data), 32'h21);
    drive(1'b0, 8'd0, 8'd0, 1'b1);
    exp_words = '{8'h12, 8'h22, 8'h13, 8'h23, 8'h14, 8'h24, 8'h15, 8'h25};
    got_q.delete();
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid) got_q.push_back(out_data);
    end
    chk("drain_count", 32'(got_q.size()), 8);
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("drain_word%0d", w),
          (w < got_q.size()) ? 32'(got_q[w]) : 32'hFFFF_FFFF, 32'(exp_words[w]));
    end
    chk("drain_level", 32'(level), 0);

    // Reset while in SEND_B with two pairs queued.
    drive(1'b1, 8'd40, 8'd41, 1'b0);
    step();
    drive(1'b1, 8'd42, 8'd43, 1'b0);
    step();
    drive(1'b1, 8'd44, 8'd45, 1'b0);
    step();
    drive(1'b0, 8'd0, 8'd0, 1'b1);
    step();
    chk("mid_pre_data", 32'(out_data), 41);
    chk("mid_pre_last", 32'(out_last), 1);
    chk("mid_pre_level", 32'(level), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("post_rst_idle_valid", 32'(out_valid), 0);
    step();
    chk("post_rst_idle_level", 32'(level), 0);
    drive(1'b1, 8'd7, 8'd9, 1'b1);
    step();
    chk("post_push_level", 32'(level), 1);
    chk("post_push_valid", 32'(out_valid), 0);
    drive(1'b0, 8'd0, 8'd0, 1'b1);
    step();
    chk("post_a_valid", 32'(out_valid), 1);
    chk("post_a_data", 32'(out_data), 7);
    step();
    chk("post_b_data", 32'(out_data), 9);
    chk("post_b_last", 32'(out_last), 1);
    step();
    chk("post_end_valid", 32'(out_valid), 0);
    step();
    chk("post_stay_idle", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
